// File: rtl/ct_sysio_flush_ctrl.sv
// L2-cache flush scheduler: merges pad/core0/core1 flush requests into one L2C req/done flush.
// Optional SYSIO_FLUSH_TIMEOUT_EN adds a REQ/DRAIN timeout limited by cfg_timeout_cycles.
module ct_sysio_flush_ctrl #(
  parameter int TMO_W = 16
) (
  input  logic             forever_cpuclk,
  input  logic             cpurst,
  input  logic             axim_clk_en,
  input  logic             pad_cpu_l2cache_flush_req,
  input  logic             core0_flush_req,
  input  logic             core1_flush_req,
  input  logic             l2c_sysio_flush_done,
  input  logic             l2c_sysio_flush_idle,
  input  logic [TMO_W-1:0] cfg_timeout_cycles,
  output logic             sysio_l2c_flush_req,
  output logic             cpu_pad_l2cache_flush_done,
  output logic             sysio_core0_flush_ack,
  output logic             sysio_core1_flush_ack,
  output logic             flush_busy,
  output logic             flush_timeout_err
);

  typedef enum logic [1:0] {IDLE, REQ, DRAIN, CMPL} state_t;

  state_t     state;
  logic [2:0] pend;
  logic [2:0] serve;
  logic       pad_req_q;
  logic [2:0] evt;
  logic       snap;
  logic       tmo_hit;
  logic       drain_ok;

  // bit0 pad (rising edge), bit1 core0, bit2 core1
  assign evt      = {core1_flush_req, core0_flush_req,
                     pad_cpu_l2cache_flush_req & ~pad_req_q};
  assign snap     = (state == IDLE) && (pend != 3'b000) && axim_clk_en && l2c_sysio_flush_idle;
  assign drain_ok = axim_clk_en && !l2c_sysio_flush_done && l2c_sysio_flush_idle;

`ifdef SYSIO_FLUSH_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_cnt;
  logic [TMO_W-1:0] tmo_nxt;

  assign tmo_nxt = tmo_cnt + 1'b1;
  // Compare the incremented count so req stays high for exactly cfg_timeout_cycles cycles.
  assign tmo_hit = ((state == REQ) || (state == DRAIN)) &&
                   (cfg_timeout_cycles != '0) && (tmo_nxt == cfg_timeout_cycles);

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      tmo_cnt           <= '0;
      flush_timeout_err <= 1'b0;
    end else begin
      if (snap)
        tmo_cnt <= '0;
      else if ((state == REQ) || (state == DRAIN))
        tmo_cnt <= tmo_nxt;
      if (tmo_hit)
        flush_timeout_err <= 1'b1;
    end
  end
`else
  logic unused_cfg;

  assign unused_cfg        = ^cfg_timeout_cycles;
  assign tmo_hit           = 1'b0;
  assign flush_timeout_err = 1'b0;
`endif

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      state                      <= IDLE;
      pend                       <= 3'b000;
      serve                      <= 3'b000;
      pad_req_q                  <= 1'b0;
      sysio_l2c_flush_req        <= 1'b0;
      cpu_pad_l2cache_flush_done <= 1'b0;
    end else begin
      pad_req_q <= pad_cpu_l2cache_flush_req;
      // Events in the snapshot cycle survive for the next flush.
      pend      <= (snap ? 3'b000 : pend) | evt;
      if (!pad_cpu_l2cache_flush_req)
        cpu_pad_l2cache_flush_done <= 1'b0;
      case (state)
        IDLE: begin
          if (snap) begin
            serve               <= pend;
            sysio_l2c_flush_req <= 1'b1;
            state               <= REQ;
          end
        end
        REQ: begin
          if (tmo_hit) begin
            sysio_l2c_flush_req <= 1'b0;
            state               <= CMPL;
            if (serve[0] && pad_cpu_l2cache_flush_req)
              cpu_pad_l2cache_flush_done <= 1'b1;
          end else if (axim_clk_en && l2c_sysio_flush_done) begin
            sysio_l2c_flush_req <= 1'b0;
            state               <= DRAIN;
          end
        end
        DRAIN: begin
          if (tmo_hit || drain_ok) begin
            state <= CMPL;
            if (serve[0] && pad_cpu_l2cache_flush_req)
              cpu_pad_l2cache_flush_done <= 1'b1;
          end
        end
        CMPL: begin
          serve <= 3'b000;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign sysio_core0_flush_ack = (state == CMPL) & serve[1];
  assign sysio_core1_flush_ack = (state == CMPL) & serve[2];
  assign flush_busy            = (state != IDLE);

endmodule
